// File: rtl/apb_decode_pkg.sv
// Shared types and helpers for the APB decoder/watchdog slice.
package apb_decode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned WDOG_WIDTH = 16;
    localparam int unsigned ERR_WIDTH  = 8;

    // Index width never collapses to zero so a single-port build still has a legal slice.
    function automatic int unsigned port_idx_width(input int unsigned num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/apb_watchdog_counter.sv
// Loadable up-counter that flags expiry once the count reaches LIMIT.
module apb_watchdog_counter
    import apb_decode_pkg::*;
#(
    parameter int unsigned WIDTH = WDOG_WIDTH,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire_c
);

    logic [WIDTH-1:0] r_count;

    // start loads 1 so the count equals the number of ACCESS cycles elapsed
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= WIDTH'(1);
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_expire_c = (r_count >= WIDTH'(LIMIT));

endmodule

// File: rtl/apb_decode_watchdog.sv
// APB 1:N address decoder with registered downstream request and hung-access watchdog.
module apb_decode_watchdog
    import apb_decode_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BLOCK_BITS = 12,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_psel,
    input  logic                            s_penable,
    input  logic                            s_pwrite,
    input  logic [ADDR_WIDTH-1:0]           s_paddr,
    input  logic [DATA_WIDTH-1:0]           s_pwdata,
    input  logic [DATA_WIDTH/8-1:0]         s_pstrb,
    output logic                            s_pready,
    output logic [DATA_WIDTH-1:0]           s_prdata,
    output logic                            s_pslverr,
    output logic [NUM_PORTS-1:0]            m_psel,
    output logic                            m_penable,
    output logic                            m_pwrite,
    output logic [BLOCK_BITS-1:0]           m_paddr,
    output logic [DATA_WIDTH-1:0]           m_pwdata,
    output logic [DATA_WIDTH/8-1:0]         m_pstrb,
    input  logic [NUM_PORTS-1:0]            m_pready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] m_prdata,
    input  logic [NUM_PORTS-1:0]            m_pslverr,
    output logic [ERR_WIDTH-1:0]            err_count,
    output logic                            busy
);

    localparam int unsigned IDX_W  = port_idx_width(NUM_PORTS);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_SETUP  = 2'(ST_SETUP);
    localparam logic [1:0] S_ACCESS = 2'(ST_ACCESS);
    localparam logic [1:0] S_RESP   = 2'(ST_RESP);

    logic [1:0]           r_state;
    logic [NUM_PORTS-1:0] r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [BLOCK_BITS-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]    r_pstrb;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_pready;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                 r_pslverr;
    logic [ERR_WIDTH-1:0] r_err_count;
    logic                 r_busy;

    logic [1:0]           w_state_nxt;
    logic [NUM_PORTS-1:0] w_psel_nxt;
    logic                 w_penable_nxt;
    logic                 w_pready_nxt;
    logic [DATA_WIDTH-1:0] w_prdata_nxt;
    logic                 w_pslverr_nxt;
    logic                 w_latch;
    logic                 w_err_inc;
    logic                 w_wd_start;
    logic                 w_wd_inc;
    logic                 w_wd_clear;
    logic                 w_wd_expire;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_unmapped;
    logic [NUM_PORTS-1:0] w_onehot;
    logic                 w_sel_ready;
    logic                 w_sel_slverr;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                 w_unused;

    // s_penable is deliberately ignored; upper address bits only alias windows
    assign w_unused   = ^{s_penable, s_paddr};
    assign w_idx      = s_paddr[BLOCK_BITS +: IDX_W];
    assign w_unmapped = (32'(w_idx) >= NUM_PORTS);
    assign w_onehot   = NUM_PORTS'(1) << w_idx;

    // Mux the latched port's completer response.
    always_comb begin
        w_sel_ready  = 1'b0;
        w_sel_slverr = 1'b0;
        w_sel_rdata  = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_ready  = m_pready[i];
                w_sel_slverr = m_pslverr[i];
                w_sel_rdata  = m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    apb_watchdog_counter #(
        .WIDTH (WDOG_WIDTH),
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_wd_start),
        .i_clear    (w_wd_clear),
        .i_inc      (w_wd_inc),
        .o_expire_c (w_wd_expire)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_pready_nxt  = 1'b0;
        w_prdata_nxt  = r_prdata;
        w_pslverr_nxt = r_pslverr;
        w_latch       = 1'b0;
        w_err_inc     = 1'b0;
        w_wd_start    = 1'b0;
        w_wd_inc      = 1'b0;
        w_wd_clear    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pslverr_nxt = 1'b0;
                if (s_psel && !r_pready) begin
                    w_latch = 1'b1;
                    if (w_unmapped) begin
                        w_state_nxt   = S_RESP;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = 1'b1;
                        w_prdata_nxt  = '0;
                        w_err_inc     = 1'b1;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_psel_nxt  = w_onehot;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
                w_wd_start    = 1'b1;
            end
            S_ACCESS: begin
                w_wd_inc = 1'b1;
                // A completer answering on the expiry cycle still wins over the abort
                if (w_sel_ready) begin
                    w_state_nxt   = S_RESP;
                    w_psel_nxt    = '0;
                    w_penable_nxt = 1'b0;
                    w_pready_nxt  = 1'b1;
                    w_prdata_nxt  = w_sel_rdata;
                    w_pslverr_nxt = w_sel_slverr;
                end else if (w_wd_expire) begin
                    w_state_nxt   = S_RESP;
                    w_psel_nxt    = '0;
                    w_penable_nxt = 1'b0;
                    w_pready_nxt  = 1'b1;
                    w_prdata_nxt  = '0;
                    w_pslverr_nxt = 1'b1;
                    w_err_inc     = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt   = S_IDLE;
                w_pslverr_nxt = 1'b0;
                w_wd_clear    = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_psel_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_idx       <= '0;
            r_pready    <= 1'b0;
            r_prdata    <= '0;
            r_pslverr   <= 1'b0;
            r_err_count <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pready  <= w_pready_nxt;
            r_prdata  <= w_prdata_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_latch) begin
                r_pwrite <= s_pwrite;
                r_paddr  <= s_paddr[BLOCK_BITS-1:0];
                r_pwdata <= s_pwdata;
                r_pstrb  <= s_pstrb;
                r_idx    <= w_idx;
            end
            if (w_err_inc && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_WIDTH'(1);
            end
        end
    end

    assign s_pready  = r_pready;
    assign s_prdata  = r_prdata;
    assign s_pslverr = r_pslverr;
    assign m_psel    = r_psel;
    assign m_penable = r_penable;
    assign m_pwrite  = r_pwrite;
    assign m_paddr   = r_paddr;
    assign m_pwdata  = r_pwdata;
    assign m_pstrb   = r_pstrb;
    assign err_count = r_err_count;
    assign busy      = r_busy;

endmodule

// File: tb/tb_apb_decode_watchdog.sv
// Bench: 4-port/TIMEOUT=255 and 3-port/TIMEOUT=4 decoders against a transaction-level model.
module tb_apb_decode_watchdog;

    localparam int TO_A = 255;
    localparam int TO_B = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_psel, s_penable, s_pwrite;
    logic [15:0] s_paddr, s_pwdata;
    logic [1:0]  s_pstrb;
    bit          use_b;

    logic        a_pready, a_pslverr, a_penable, a_pwrite, a_busy;
    logic [15:0] a_prdata, a_pwdata;
    logic [3:0]  a_psel, a_m_pready, a_m_pslverr;
    logic [11:0] a_paddr;
    logic [1:0]  a_pstrb;
    logic [63:0] a_m_prdata;
    logic [7:0]  a_err;

    logic        b_pready, b_pslverr, b_penable, b_pwrite, b_busy;
    logic [15:0] b_prdata, b_pwdata;
    logic [2:0]  b_psel, b_m_pready, b_m_pslverr;
    logic [11:0] b_paddr;
    logic [1:0]  b_pstrb;
    logic [47:0] b_m_prdata;
    logic [7:0]  b_err;

    int          cfg_port = -1;
    int          cfg_wait = 0;
    logic [15:0] cfg_rd = '0;
    bit          cfg_err = 1'b0;
    int          acc_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int err_a = 0;
    int err_b = 0;

    apb_decode_watchdog #(.NUM_PORTS(4), .TIMEOUT(TO_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .s_psel(s_psel & ~use_b), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_pready(a_pready), .s_prdata(a_prdata), .s_pslverr(a_pslverr),
        .m_psel(a_psel), .m_penable(a_penable), .m_pwrite(a_pwrite),
        .m_paddr(a_paddr), .m_pwdata(a_pwdata), .m_pstrb(a_pstrb),
        .m_pready(a_m_pready), .m_prdata(a_m_prdata), .m_pslverr(a_m_pslverr),
        .err_count(a_err), .busy(a_busy)
    );

    apb_decode_watchdog #(.NUM_PORTS(3), .TIMEOUT(TO_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .s_psel(s_psel & use_b), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_pready(b_pready), .s_prdata(b_prdata), .s_pslverr(b_pslverr),
        .m_psel(b_psel), .m_penable(b_penable), .m_pwrite(b_pwrite),
        .m_paddr(b_paddr), .m_pwdata(b_pwdata), .m_pstrb(b_pstrb),
        .m_pready(b_m_pready), .m_prdata(b_m_prdata), .m_pslverr(b_m_pslverr),
        .err_count(b_err), .busy(b_busy)
    );

    // Completers: only the intended port answers; every other port returns inverted data/error.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_m_prdata[i*16 +: 16] = (i == cfg_port) ? cfg_rd : ~cfg_rd;
            a_m_pslverr[i] = (i == cfg_port) ? cfg_err : ~cfg_err;
            a_m_pready[i]  = (i == cfg_port) && a_psel[i] && a_penable && (acc_cnt == cfg_wait);
        end
        for (int i = 0; i < 3; i++) begin
            b_m_prdata[i*16 +: 16] = (i == cfg_port) ? cfg_rd : ~cfg_rd;
            b_m_pslverr[i] = (i == cfg_port) ? cfg_err : ~cfg_err;
            b_m_pready[i]  = (i == cfg_port) && b_psel[i] && b_penable && (acc_cnt == cfg_wait);
        end
    end

    // Number of ACCESS cycles already completed on the active downstream bus.
    always @(posedge clk) begin
        acc_cnt <= (a_penable || b_penable) ? acc_cnt + 1 : 0;
    end

    logic        sp_ready, sp_slverr, mp_penable, mp_pwrite, sp_busy;
    logic [15:0] sp_prdata, mp_pwdata;
    logic [3:0]  mp_psel;
    logic [11:0] mp_paddr;
    logic [1:0]  mp_pstrb;
    logic [7:0]  sp_err;

    assign sp_ready   = use_b ? b_pready   : a_pready;
    assign sp_slverr  = use_b ? b_pslverr  : a_pslverr;
    assign sp_prdata  = use_b ? b_prdata   : a_prdata;
    assign sp_busy    = use_b ? b_busy     : a_busy;
    assign sp_err     = use_b ? b_err      : a_err;
    assign mp_psel    = use_b ? {1'b0, b_psel} : a_psel;
    assign mp_penable = use_b ? b_penable  : a_penable;
    assign mp_pwrite  = use_b ? b_pwrite   : a_pwrite;
    assign mp_paddr   = use_b ? b_paddr    : a_paddr;
    assign mp_pwdata  = use_b ? b_pwdata   : a_pwdata;
    assign mp_pstrb   = use_b ? b_pstrb    : a_pstrb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level expectation: window index from address bits [13:12].
    function automatic void model(input bit b, input logic [15:0] addr, input int waits,
                                  input logic [15:0] rd, input bit cerr,
                                  output int lat, output logic [15:0] prd, output bit perr,
                                  output int port, output bit err_ev);
        int np;
        int to;
        np   = b ? 3 : 4;
        to   = b ? TO_B : TO_A;
        port = int'((addr >> 12) & 16'h3);
        if (port >= np) begin
            port = -1; lat = 1; prd = '0; perr = 1'b1; err_ev = 1'b1;
        end else if (waits < to) begin
            lat = waits + 3; prd = rd; perr = cerr; err_ev = 1'b0;
        end else begin
            lat = to + 2; prd = '0; perr = 1'b1; err_ev = 1'b1;
        end
    endfunction

    task automatic xfer(input bit b, input logic [15:0] addr, input bit wr, input logic [15:0] wd,
                        input logic [1:0] st, input int waits, input logic [15:0] rd,
                        input bit cerr, input string tag);
        int lat_exp, port, lat, limit;
        logic [15:0] prd_exp;
        logic [11:0] off;
        logic [3:0]  psel_exp;
        bit perr_exp, err_ev, got, drv_bad;
        model(b, addr, waits, rd, cerr, lat_exp, prd_exp, perr_exp, port, err_ev);
        if (err_ev) begin
            if (b) err_b = (err_b < 255) ? err_b + 1 : 255;
            else   err_a = (err_a < 255) ? err_a + 1 : 255;
        end
        psel_exp = (port >= 0) ? 4'(1 << port) : 4'b0;
        off      = addr[11:0];
        limit    = (b ? TO_B : TO_A) + 20;
        use_b = b; cfg_port = port; cfg_wait = waits; cfg_rd = rd; cfg_err = cerr;
        @(negedge clk);
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr;
        s_paddr = addr; s_pwdata = wd; s_pstrb = st;
        lat = 0; got = 1'b0; drv_bad = 1'b0;
        while (!got && lat < limit) begin
            @(negedge clk);
            lat++;
            s_penable = 1'b1;
            if (sp_ready) begin
                got = 1'b1;
                if (mp_psel != 4'b0 || mp_penable) drv_bad = 1'b1;
            end else begin
                if (mp_psel !== psel_exp || mp_paddr !== off || mp_pwrite !== wr ||
                    mp_pwdata !== wd || mp_pstrb !== st) drv_bad = 1'b1;
                if (lat == 1 && mp_penable) drv_bad = 1'b1;
                if (lat >= 2 && !mp_penable) drv_bad = 1'b1;
            end
        end
        check({tag, "_got_pready"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_prdata"}, 32'(sp_prdata), 32'(prd_exp));
        check({tag, "_pslverr"}, 32'(sp_slverr), 32'(perr_exp));
        check({tag, "_downstream"}, 32'(drv_bad), 32'd0);
        s_psel = 1'b0; s_penable = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_end"}, {29'd0, sp_ready, sp_busy, sp_slverr}, 32'd0);
        check({tag, "_prdata_hold"}, 32'(sp_prdata), 32'(prd_exp));
        check({tag, "_err_count"}, 32'(sp_err), 32'(b ? err_b : err_a));
    endtask

    initial begin
        rst = 1'b1; use_b = 1'b0;
        s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
        s_paddr = '0; s_pwdata = '0; s_pstrb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_a_up", {14'd0, a_pready, a_pslverr, a_prdata}, 32'd0);
        check("rst_a_dn", {a_psel, a_penable, a_pwrite, a_paddr, a_pstrb, 12'd0}, 32'd0);
        check("rst_a_wd", {16'd0, a_pwdata}, 32'd0);
        check("rst_a_misc", {23'd0, a_busy, a_err}, 32'd0);
        check("rst_b_all", {b_pready, b_pslverr, b_psel, b_penable, b_pwrite, b_busy, b_err,
                            b_paddr, b_pstrb}, 32'd0);
        check("rst_b_data", {b_prdata, b_pwdata}, 32'd0);

        xfer(1'b0, 16'h1234, 1'b0, 16'h0000, 2'b11, 0, 16'hBEEF, 1'b0, "rd_p1_zw");
        check("rd_p1_value", 32'(a_prdata), 32'h0000_BEEF);
        xfer(1'b0, 16'h3010, 1'b1, 16'hA55A, 2'b01, 5, 16'h0F0F, 1'b0, "wr_p3_w5");
        xfer(1'b0, 16'h0100, 1'b0, 16'h0000, 2'b11, 100000, 16'h1111, 1'b0, "to_a");
        check("to_a_err1", 32'(a_err), 32'd1);
        xfer(1'b0, 16'h2000, 1'b0, 16'h0000, 2'b11, TO_A - 1, 16'h5A5A, 1'b1, "edge_ok_err");
        xfer(1'b0, 16'h2002, 1'b0, 16'h0000, 2'b10, TO_A - 1, 16'hC3C3, 1'b0, "edge_ok");
        xfer(1'b0, 16'h2004, 1'b0, 16'h0000, 2'b01, TO_A, 16'h7777, 1'b0, "edge_to");
        xfer(1'b1, 16'h3000, 1'b0, 16'h0000, 2'b11, 0, 16'h9999, 1'b0, "unmapped_b");

        // Reset in the middle of a downstream ACCESS phase.
        use_b = 1'b0; cfg_port = 2; cfg_wait = 50; cfg_rd = 16'h4242; cfg_err = 1'b0;
        @(negedge clk);
        s_psel = 1'b1; s_pwrite = 1'b1; s_paddr = 16'h2040; s_pwdata = 16'h1357; s_pstrb = 2'b11;
        @(negedge clk);
        s_penable = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_access", {30'd0, a_penable, a_busy}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
        check("mid_rst_up", {7'd0, a_pready, a_pslverr, a_busy, a_err, a_prdata}, 32'd0);
        check("mid_rst_dn", {a_psel, a_penable, a_pwrite, a_paddr, a_pstrb, a_pwdata[11:0]}, 32'd0);
        check("mid_rst_b", {22'd0, b_busy, b_err, b_pslverr}, 32'd0);
        err_a = 0; err_b = 0;
        @(negedge clk);
        check("post_rst_no_resp", {30'd0, a_pready, a_busy}, 32'd0);
        xfer(1'b0, 16'h2040, 1'b1, 16'h1357, 2'b11, 2, 16'h4242, 1'b0, "after_rst");

        for (int k = 0; k < 40; k++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            xfer(b, 16'($urandom), 1'($urandom), 16'($urandom), 2'($urandom),
                 b ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 8)),
                 16'($urandom), ($urandom_range(0, 3) == 0), "rand");
        end

        for (int k = 0; k < 300; k++) begin
            xfer(1'b1, 16'h1000 + 16'(k), 1'b0, 16'h0000, 2'b11, 1000, 16'hDEAD, 1'b0, "sat");
        end
        check("sat_final", 32'(b_err), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
